meas_accum_core: RTL and testbench

Parametrised multi-channel measurement accumulator for the VNA DSP path. It takes per-channel ADC samples qualified by a strobe, discards a programmable number of settling samples, then sums a programmable number of samples per channel into saturating signed accumulators. It asserts `meas_done` with stable results for the SPI readout logic. It sits between the ADC capture pins and the SPI peripheral in `dsp_core`, generalising the fixed two-channel, 12-bit path to N channels of configurable width.

---
 rtl/meas_accum_core.sv | 127 ++++++++++++
 tb/tb_meas_accum_core.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_accum_core.sv
// rtl/meas_accum_core.sv - multi-channel settle/accumulate measurement core
// Skips n_skip strobes, then sums n_samples strobes per channel into saturating accumulators.
module meas_accum_core #(
  parameter int NCH        = 2,
  parameter int ADC_W      = 12,
  parameter int ACC_W      = 32,
  parameter int CNT_W      = 16,
  parameter int OFFSET_BIN = 1
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   adc_valid,
  input  logic [NCH*ADC_W-1:0]   adc_data,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       n_samples,
  input  logic [CNT_W-1:0]       n_skip,
  output logic                   busy,
  output logic                   meas_done,
  output logic [NCH*ACC_W-1:0]   result,
  output logic [NCH-1:0]         ovf
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_DONE} state_t;

  localparam logic [ADC_W-1:0] MSB_FLIP = {OFFSET_BIN != 0, {(ADC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             ns_r, skip_r, cnt, cnt_inc;
  logic [NCH-1:0][ACC_W-1:0]    acc, acc_nxt;
  logic [NCH-1:0]               wovf, wovf_nxt;
  logic                         start_ok;

  assign cnt_inc   = cnt + 1'b1;
  assign busy      = (state == S_SETTLE) || (state == S_ACCUM);
  assign meas_done = (state == S_DONE);
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));

  // One guard bit above the accumulator detects signed overflow of each add.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [ADC_W-1:0] raw;
    logic [ACC_W:0]   sum;
    logic             sat;

    assign raw         = adc_data[k*ADC_W +: ADC_W] ^ MSB_FLIP;
    assign sum         = {acc[k][ACC_W-1], acc[k]} + {{(ACC_W+1-ADC_W){raw[ADC_W-1]}}, raw};
    assign sat         = sum[ACC_W] != sum[ACC_W-1];
    assign acc_nxt[k]  = sat ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    assign wovf_nxt[k] = wovf[k] | sat;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (n_skip != '0)         state_nxt = S_SETTLE;
          else if (n_samples != '0) state_nxt = S_ACCUM;
          else                      state_nxt = S_DONE;
        end
      end
      S_SETTLE: begin
        if (abort)                                state_nxt = S_IDLE;
        else if (adc_valid && cnt_inc == skip_r)  state_nxt = (ns_r != '0) ? S_ACCUM : S_DONE;
      end
      S_ACCUM: begin
        if (abort)                                state_nxt = S_IDLE;
        else if (adc_valid && cnt_inc == ns_r)    state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Abort takes priority over a coincident strobe so a cancelled run never publishes.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ns_r   <= '0;
      skip_r <= '0;
      cnt    <= '0;
      acc    <= '0;
      wovf   <= '0;
      result <= '0;
      ovf    <= '0;
    end else if (start_ok) begin
      ns_r   <= n_samples;
      skip_r <= n_skip;
      cnt    <= '0;
      acc    <= '0;
      wovf   <= '0;
      if (n_skip == '0 && n_samples == '0) begin
        result <= '0;
        ovf    <= '0;
      end
    end else if (busy && abort) begin
      cnt <= '0;
    end else if (state == S_SETTLE && adc_valid) begin
      if (cnt_inc == skip_r) begin
        cnt <= '0;
        if (ns_r == '0) begin
          result <= '0;
          ovf    <= '0;
        end
      end else begin
        cnt <= cnt_inc;
      end
    end else if (state == S_ACCUM && adc_valid) begin
      acc  <= acc_nxt;
      wovf <= wovf_nxt;
      cnt  <= cnt_inc;
      if (cnt_inc == ns_r) begin
        result <= acc_nxt;
        ovf    <= wovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_meas_accum_core.sv
// tb/tb_meas_accum_core.sv - randomized bench for meas_accum_core against a sum/clamp model
// Two instances share stimulus: a narrow two's-complement one and a wide offset-binary one.
module tb_meas_accum_core;

  localparam int NCH   = 2;
  localparam int ADC_W = 12;
  localparam int CNT_W = 8;
  localparam int AW_A  = 14;
  localparam int AW_B  = 32;

  logic                  sys_clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  adc_valid = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [NCH*ADC_W-1:0]  adc_data = '0;
  logic [CNT_W-1:0]      n_samples = '0;
  logic [CNT_W-1:0]      n_skip = '0;
  logic                  busy_a, done_a, busy_b, done_b;
  logic [NCH*AW_A-1:0]   result_a;
  logic [NCH*AW_B-1:0]   result_b;
  logic [NCH-1:0]        ovf_a, ovf_b;

  int                    vectors = 0;
  int                    miscompares = 0;
  longint                exp_a [NCH];
  longint                exp_b [NCH];
  logic [NCH-1:0]        eovf_a, eovf_b;
  bit                    in_done;
  logic [NCH*ADC_W-1:0]  pat [$];

  always #5 sys_clk = ~sys_clk;

  meas_accum_core #(.NCH(NCH), .ADC_W(ADC_W), .ACC_W(AW_A), .CNT_W(CNT_W), .OFFSET_BIN(0)) dut_a (
    .sys_clk(sys_clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
    .start(start), .abort(abort), .n_samples(n_samples), .n_skip(n_skip),
    .busy(busy_a), .meas_done(done_a), .result(result_a), .ovf(ovf_a)
  );

  meas_accum_core #(.NCH(NCH), .ADC_W(ADC_W), .ACC_W(AW_B), .CNT_W(CNT_W), .OFFSET_BIN(1)) dut_b (
    .sys_clk(sys_clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
    .start(start), .abort(abort), .n_samples(n_samples), .n_skip(n_skip),
    .busy(busy_b), .meas_done(done_b), .result(result_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic longint res_a(input int k);
    return longint'($signed(result_a[k*AW_A +: AW_A]));
  endfunction

  function automatic longint res_b(input int k);
    return longint'($signed(result_b[k*AW_B +: AW_B]));
  endfunction

  function automatic longint hi_of(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sval(input logic [ADC_W-1:0] r, input bit ob);
    logic [ADC_W-1:0] x;
    x = r;
    if (ob) x[ADC_W-1] = ~x[ADC_W-1];
    return longint'($signed(x));
  endfunction

  function automatic logic [NCH*ADC_W-1:0] pk(input int c0, input int c1);
    logic [31:0] a, b;
    a = c0;
    b = c1;
    return {b[ADC_W-1:0], a[ADC_W-1:0]};
  endfunction

  task automatic check_outputs(input string tag, input bit exp_busy);
    check({tag, ".busy_a"}, busy_a, exp_busy);
    check({tag, ".busy_b"}, busy_b, exp_busy);
    check({tag, ".done_a"}, done_a, in_done);
    check({tag, ".done_b"}, done_b, in_done);
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("%s.res_a%0d", tag, k), res_a(k), exp_a[k]);
      check($sformatf("%s.res_b%0d", tag, k), res_b(k), exp_b[k]);
    end
    check({tag, ".ovf_a"}, ovf_a, eovf_a);
    check({tag, ".ovf_b"}, ovf_b, eovf_b);
  endtask

  // Clamp-after-every-add model: a saturated accumulator sticks at the rail until pulled back.
  task automatic run_meas(input string tag, input int ns, input int nsk, input int abort_at, input bit abort_on_start);
    longint         acc_a [NCH];
    longint         acc_b [NCH];
    logic [NCH-1:0] wo_a, wo_b;
    int             skipped, taken, cyc, limit;
    bit             v;
    logic [NCH*ADC_W-1:0] d;
    wo_a = '0;
    wo_b = '0;
    skipped = 0;
    taken = 0;
    cyc = 0;
    limit = (ns + nsk) * 6 + 40;
    for (int k = 0; k < NCH; k++) begin
      acc_a[k] = 0;
      acc_b[k] = 0;
    end
    n_samples = CNT_W'(ns);
    n_skip = CNT_W'(nsk);
    start = 1'b1;
    abort = abort_on_start;
    adc_valid = 1'($urandom_range(0, 1));
    adc_data = NCH*ADC_W'($urandom);
    tick();
    start = 1'b0;
    abort = 1'b0;
    adc_valid = 1'b0;
    in_done = 1'b0;
    while (skipped < nsk || taken < ns) begin
      check_outputs({tag, ".run"}, 1'b1);
      if (abort_at >= 0 && taken == abort_at && skipped == nsk) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_outputs({tag, ".abort"}, 1'b0);
        return;
      end
      if (pat.size() != 0) begin
        v = 1'b1;
        d = pat.pop_front();
      end else begin
        v = ($urandom_range(0, 9) < 7);
        d = NCH*ADC_W'($urandom);
      end
      adc_valid = v;
      adc_data = d;
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1;
        n_samples = CNT_W'($urandom);
        n_skip = CNT_W'($urandom);
      end
      tick();
      start = 1'b0;
      adc_valid = 1'b0;
      if (v) begin
        if (skipped < nsk) begin
          skipped++;
        end else begin
          taken++;
          for (int k = 0; k < NCH; k++) begin
            acc_a[k] += sval(d[k*ADC_W +: ADC_W], 1'b0);
            acc_b[k] += sval(d[k*ADC_W +: ADC_W], 1'b1);
            if (acc_a[k] > hi_of(AW_A)) begin acc_a[k] = hi_of(AW_A); wo_a[k] = 1'b1; end
            else if (acc_a[k] < -hi_of(AW_A) - 1) begin acc_a[k] = -hi_of(AW_A) - 1; wo_a[k] = 1'b1; end
            if (acc_b[k] > hi_of(AW_B)) begin acc_b[k] = hi_of(AW_B); wo_b[k] = 1'b1; end
            else if (acc_b[k] < -hi_of(AW_B) - 1) begin acc_b[k] = -hi_of(AW_B) - 1; wo_b[k] = 1'b1; end
          end
        end
      end
      cyc++;
      if (cyc > limit) begin
        check({tag, ".timeout"}, 1, 0);
        return;
      end
    end
    for (int k = 0; k < NCH; k++) begin
      exp_a[k] = acc_a[k];
      exp_b[k] = acc_b[k];
    end
    eovf_a = wo_a;
    eovf_b = wo_b;
    in_done = 1'b1;
    check_outputs({tag, ".done"}, 1'b0);
  endtask

  // Strobes and aborts outside a measurement must not disturb anything.
  task automatic idle_noise(input string tag);
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      adc_data = NCH*ADC_W'($urandom);
      tick();
      adc_valid = 1'b0;
      abort = 1'b0;
      check_outputs({tag, ".idle"}, 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin
      exp_a[k] = 0;
      exp_b[k] = 0;
    end
    eovf_a = '0;
    eovf_b = '0;
    in_done = 1'b0;

    tick();
    tick();
    check_outputs("reset", 1'b0);
    rst = 1'b1;
    tick();
    check_outputs("post_reset", 1'b0);

    pat = '{pk(100, -1), pk(-50, -1), pk(25, -1), pk(1, -1)};
    run_meas("tp1", 4, 0, -1, 1'b0);
    check("tp1.ch0_const", res_a(0), 76);
    check("tp1.ch1_const", res_a(1), -4);
    check("tp1.ovf_const", ovf_a, 0);
    idle_noise("tp1");

    pat = '{pk(0, 0), pk('hFFF, 0), pk('h800, 0), pk('h801, 0)};
    run_meas("tp2", 2, 2, -1, 1'b0);
    check("tp2.ch0_const", res_b(0), 1);

    pat = '{pk(2047, 0), pk(2047, 0), pk(2047, 0), pk(2047, 0), pk(2047, 0)};
    run_meas("tp3", 5, 0, -1, 1'b0);
    check("tp3.ch0_const", res_a(0), 8191);
    check("tp3.ch1_const", res_a(1), 0);
    check("tp3.ovf_const", ovf_a, 2'b01);

    run_meas("tp4", 0, 0, -1, 1'b0);
    check("tp4.ch0_zero", res_a(0), 0);
    run_meas("tp4b", 0, 3, -1, 1'b0);
    idle_noise("tp4");

    run_meas("tp5_seed", 3, 0, -1, 1'b0);
    run_meas("tp5_abort", 4, 0, 2, 1'b0);
    idle_noise("tp5");
    run_meas("tp5_fresh", 4, 1, -1, 1'b1);

    n_samples = 8'd6;
    n_skip = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    adc_valid = 1'b1;
    adc_data = pk(5, 9);
    tick();
    tick();
    adc_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NCH; k++) begin
      exp_a[k] = 0;
      exp_b[k] = 0;
    end
    eovf_a = '0;
    eovf_b = '0;
    in_done = 1'b0;
    check_outputs("tp6.async_reset", 1'b0);
    tick();
    rst = 1'b1;
    tick();
    pat = '{pk(7, 0), pk(7, 0), pk(7, 0)};
    run_meas("tp6", 3, 0, -1, 1'b0);
    check("tp6.ch0_const", res_a(0), 21);

    for (int i = 0; i < 30; i++) begin
      int ns, nsk, ab;
      ns = $urandom_range(0, 12);
      nsk = $urandom_range(0, 4);
      ab = (ns > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, ns - 1)) : -1;
      run_meas($sformatf("rnd%0d", i), ns, nsk, ab, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_noise($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
